// File: rtl/activation_pkg.sv
// ============================================================================
// Module      : activation_pkg
// Description : Shared widths, types and saturation bounds for the
//               piecewise-linear activation stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package activation_pkg;

    localparam int IN_W   = 8;
    localparam int ADDR_W = 4;
    localparam int FRAC_W = IN_W - ADDR_W;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] SEG_POS_MAX = ADDR_W'((2 ** (ADDR_W - 1)) - 1);

    localparam int ACT_MIN = -(2 ** (DATA_W - 1));
    localparam int ACT_MAX = (2 ** (DATA_W - 1)) - 1;

    typedef logic [ADDR_W-1:0]        seg_t;
    typedef logic [FRAC_W-1:0]        frac_t;
    typedef logic signed [DATA_W-1:0] act_t;

endpackage

`default_nettype wire

// File: rtl/activation_lut_interp_mac.sv
// ============================================================================
// Module      : interp_mac
// Description : Combinational interpolate-and-saturate: base + (next-base)*frac
//               scaled by 2^-FRAC_W. Rounding selected by INTERP_ROUND_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interp_mac
    import activation_pkg::*;
(
    input  act_t  base,
    input  act_t  nxt,
    input  frac_t frac,
    output act_t  res
);

    // Wide enough for the full 9x5 signed product plus the base addition.
    localparam int W = DATA_W + FRAC_W + 2;

`ifdef INTERP_ROUND_EN
    localparam logic signed [W-1:0] c_rnd = W'(2 ** (FRAC_W - 1));
`else
    localparam logic signed [W-1:0] c_rnd = '0;
`endif

    localparam logic signed [W-1:0] c_max = W'(ACT_MAX);
    localparam logic signed [W-1:0] c_min = W'(ACT_MIN);

    logic signed [DATA_W:0] w_diff;
    logic signed [W-1:0]    w_diff_x;
    logic signed [W-1:0]    w_frac_x;
    logic signed [W-1:0]    w_prod;
    logic signed [W-1:0]    w_shift;
    logic signed [W-1:0]    w_base_x;
    logic signed [W-1:0]    w_sum;

    assign w_diff   = {nxt[DATA_W-1], nxt} - {base[DATA_W-1], base};
    assign w_diff_x = W'(w_diff);
    assign w_frac_x = W'($signed({1'b0, frac}));
    assign w_prod   = w_diff_x * w_frac_x;
    assign w_shift  = (w_prod + c_rnd) >>> FRAC_W;
    assign w_base_x = W'(base);
    assign w_sum    = w_shift + w_base_x;

    always_comb begin
        res = w_sum[DATA_W-1:0];
        if (w_sum > c_max) begin
            res = c_max[DATA_W-1:0];
        end else if (w_sum < c_min) begin
            res = c_min[DATA_W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/activation_lut_interp.sv
// ============================================================================
// Module      : activation_lut_interp
// Description : 3-stage valid/ready piecewise-linear activation around an
//               external 16-entry LUT. Optional macro: INTERP_ROUND_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module activation_lut_interp
    import activation_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    output logic [ADDR_W-1:0] lut_addr,
    input  logic [DATA_W-1:0] lut_base,
    input  logic [DATA_W-1:0] lut_next,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic  w_adv;
    logic  w_accept;
    act_t  w_res;

    logic  r_v1;
    frac_t r_f1;
    logic  r_v2;
    frac_t r_f2;
    act_t  r_b2;
    act_t  r_n2;

    // The whole pipe moves as one; only a held output blocks it.
    assign w_adv    = !out_valid || out_ready;
    assign w_accept = in_valid && w_adv;
    assign in_ready = w_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            lut_addr  <= '0;
            r_f1      <= '0;
            r_v1      <= 1'b0;
            r_b2      <= '0;
            r_n2      <= '0;
            r_f2      <= '0;
            r_v2      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (w_adv) begin
            r_v1      <= in_valid;
            r_v2      <= r_v1;
            out_valid <= r_v2;
            if (w_accept) begin
                lut_addr <= in_data[IN_W-1 -: ADDR_W];
                r_f1     <= in_data[FRAC_W-1:0];
            end
            if (r_v1) begin
                r_b2 <= lut_base;
                r_f2 <= r_f1;
                // Never blend the top positive segment into the most negative entry.
                r_n2 <= (lut_addr == SEG_POS_MAX) ? lut_base : lut_next;
            end
            if (r_v2) begin
                out_data <= w_res;
            end
        end
    end

    interp_mac u_mac (
        .base (r_b2),
        .nxt  (r_n2),
        .frac (r_f2),
        .res  (w_res)
    );

endmodule

`default_nettype wire
